// File: rtl/klp32_commit_checker.sv
// Table-driven commit scoreboard for the KLP32 core: compares each committed
// instruction's observed channels against a programmable golden table.
module klp32_commit_checker #(
  parameter int XLEN         = 32,
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 64,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW  = $clog2(DEPTH),
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NW  = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [NW-1:0]          i_num_entries,
  input  logic                   i_valid,
  input  logic [NUM_CH*XLEN-1:0] i_obs,
  input  logic                   i_prog_we,
  input  logic [AW-1:0]          i_prog_addr,
  input  logic [CHW-1:0]         i_prog_ch,
  input  logic [XLEN-1:0]        i_prog_data,
  input  logic                   i_prog_mask,
  output logic [1:0]             o_state,
  output logic [CNT_W-1:0]       o_num_tests,
  output logic [CNT_W-1:0]       o_num_passes,
  output logic                   o_fail,
  output logic [AW-1:0]          o_first_fail_idx,
  output logic [CHW-1:0]         o_first_fail_ch,
  output logic                   o_done
);

  localparam int PW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    ptr_q, ptr_d, num_q, num_d;
  logic [CNT_W-1:0] tests_q, tests_d, passes_q, passes_d;
  logic             fail_q, fail_d;
  logic [AW-1:0]    ffi_q, ffi_d;
  logic [CHW-1:0]   ffc_q, ffc_d;

  // Golden table is deliberately left out of reset so it survives aborted runs.
  logic [XLEN-1:0]   gold_val  [DEPTH][NUM_CH];
  logic [NUM_CH-1:0] gold_mask [DEPTH];

  always_ff @(posedge clk) begin
    if (i_prog_we && (state_q != S_RUN) && (int'(i_prog_ch) < NUM_CH)) begin
      gold_val[i_prog_addr][i_prog_ch]  <= i_prog_data;
      gold_mask[i_prog_addr][i_prog_ch] <= i_prog_mask;
    end
  end

  logic [NUM_CH-1:0] cur_mask, miss;
  logic [PW-1:0]     n_chk, n_hit;
  logic [CHW-1:0]    miss_ch;
  logic [NW-1:0]     num_clamped;

  always_comb begin
    cur_mask = gold_mask[ptr_q[AW-1:0]];
    miss     = '0;
    n_chk    = '0;
    n_hit    = '0;
    miss_ch  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_mask[c]) begin
        n_chk = n_chk + PW'(1);
        if (i_obs[c*XLEN +: XLEN] == gold_val[ptr_q[AW-1:0]][c]) n_hit = n_hit + PW'(1);
        else miss[c] = 1'b1;
      end
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (miss[c]) miss_ch = CHW'(c);
    end
    num_clamped = (i_num_entries > NW'(DEPTH)) ? NW'(DEPTH) : i_num_entries;
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
    logic [CNT_W+PW-1:0] s;
    s = {{PW{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    if (s > (CNT_W+PW)'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    num_d    = num_q;
    tests_d  = tests_q;
    passes_d = passes_q;
    fail_d   = fail_q;
    ffi_d    = ffi_q;
    ffc_d    = ffc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          num_d    = num_clamped;
          ptr_d    = '0;
          tests_d  = '0;
          passes_d = '0;
          fail_d   = 1'b0;
          ffi_d    = '0;
          ffc_d    = '0;
          state_d  = (num_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_valid) begin
          tests_d  = sat_add(tests_q, n_chk);
          passes_d = sat_add(passes_q, n_hit);
          ptr_d    = ptr_q + NW'(1);
          if ((miss != '0) && !fail_q) begin
            fail_d = 1'b1;
            ffi_d  = ptr_q[AW-1:0];
            ffc_d  = miss_ch;
          end
          if ((ptr_q == num_q - NW'(1)) || ((STOP_ON_FAIL != 0) && (miss != '0)))
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      num_q    <= '0;
      tests_q  <= '0;
      passes_q <= '0;
      fail_q   <= 1'b0;
      ffi_q    <= '0;
      ffc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      num_q    <= num_d;
      tests_q  <= tests_d;
      passes_q <= passes_d;
      fail_q   <= fail_d;
      ffi_q    <= ffi_d;
      ffc_q    <= ffc_d;
    end
  end

  assign o_state          = state_q;
  assign o_num_tests      = tests_q;
  assign o_num_passes     = passes_q;
  assign o_fail           = fail_q;
  assign o_first_fail_idx = ffi_q;
  assign o_first_fail_ch  = ffc_q;
  assign o_done           = (state_q == S_DONE);

endmodule

// File: tb/tb_klp32_commit_checker.sv
// Bench for klp32_commit_checker: three instances (default, stop-on-fail,
// 4-bit counters) share stimulus; directed scenarios plus a randomized model run.
module tb_klp32_commit_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_start;
  logic [6:0]   i_num_entries;
  logic         i_valid;
  logic [127:0] i_obs;
  logic         i_prog_we;
  logic [5:0]   i_prog_addr;
  logic [1:0]   i_prog_ch;
  logic [31:0]  i_prog_data;
  logic         i_prog_mask;

  logic [1:0]  d_state  [3];
  logic [15:0] d_tests  [3];
  logic [15:0] d_passes [3];
  logic        d_fail   [3];
  logic [5:0]  d_idx    [3];
  logic [1:0]  d_ch     [3];
  logic        d_done   [3];
  logic [3:0]  sat_tests, sat_passes;

  always #5 clk = ~clk;

  klp32_commit_checker u_main (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_entries(i_num_entries),
    .i_valid(i_valid), .i_obs(i_obs), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_ch(i_prog_ch), .i_prog_data(i_prog_data), .i_prog_mask(i_prog_mask),
    .o_state(d_state[0]), .o_num_tests(d_tests[0]), .o_num_passes(d_passes[0]),
    .o_fail(d_fail[0]), .o_first_fail_idx(d_idx[0]), .o_first_fail_ch(d_ch[0]),
    .o_done(d_done[0]));

  klp32_commit_checker #(.STOP_ON_FAIL(1)) u_stop (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_entries(i_num_entries),
    .i_valid(i_valid), .i_obs(i_obs), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_ch(i_prog_ch), .i_prog_data(i_prog_data), .i_prog_mask(i_prog_mask),
    .o_state(d_state[1]), .o_num_tests(d_tests[1]), .o_num_passes(d_passes[1]),
    .o_fail(d_fail[1]), .o_first_fail_idx(d_idx[1]), .o_first_fail_ch(d_ch[1]),
    .o_done(d_done[1]));

  klp32_commit_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_entries(i_num_entries),
    .i_valid(i_valid), .i_obs(i_obs), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_ch(i_prog_ch), .i_prog_data(i_prog_data), .i_prog_mask(i_prog_mask),
    .o_state(d_state[2]), .o_num_tests(sat_tests), .o_num_passes(sat_passes),
    .o_fail(d_fail[2]), .o_first_fail_idx(d_idx[2]), .o_first_fail_ch(d_ch[2]),
    .o_done(d_done[2]));

  assign d_tests[2]  = {12'b0, sat_tests};
  assign d_passes[2] = {12'b0, sat_passes};

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: one golden table and run record per instance.
  logic [31:0] g_val  [3][64][4];
  bit          g_mask [3][64][4];
  int m_st[3], m_ptr[3], m_num[3], m_tests[3], m_passes[3], m_idx[3], m_ch[3];
  bit m_fail[3];
  int cmax[3]  = '{65535, 65535, 15};
  bit cstop[3] = '{1'b0, 1'b1, 1'b0};

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int oldst, t, p, first;
      oldst = m_st[k];
      if (i_prog_we && oldst != 1) begin
        g_val[k][i_prog_addr][i_prog_ch]  = i_prog_data;
        g_mask[k][i_prog_addr][i_prog_ch] = i_prog_mask;
      end
      if (reset) begin
        m_st[k] = 0; m_ptr[k] = 0; m_tests[k] = 0; m_passes[k] = 0;
        m_fail[k] = 0; m_idx[k] = 0; m_ch[k] = 0;
      end else if (oldst != 1) begin
        if (i_start) begin
          m_num[k] = clip(int'(i_num_entries), 64);
          m_ptr[k] = 0; m_tests[k] = 0; m_passes[k] = 0;
          m_fail[k] = 0; m_idx[k] = 0; m_ch[k] = 0;
          m_st[k] = (m_num[k] == 0) ? 2 : 1;
        end
      end else if (i_valid) begin
        t = 0; p = 0; first = -1;
        for (int c = 0; c < 4; c++) begin
          if (g_mask[k][m_ptr[k]][c]) begin
            t++;
            if (i_obs[c*32 +: 32] == g_val[k][m_ptr[k]][c]) p++;
            else if (first < 0) first = c;
          end
        end
        m_tests[k]  = clip(m_tests[k] + t, cmax[k]);
        m_passes[k] = clip(m_passes[k] + p, cmax[k]);
        if (first >= 0 && !m_fail[k]) begin
          m_fail[k] = 1; m_idx[k] = m_ptr[k]; m_ch[k] = first;
        end
        if (m_ptr[k] == m_num[k] - 1 || (cstop[k] && first >= 0)) m_st[k] = 2;
        m_ptr[k]++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  task automatic start(input int n);
    i_start = 1'b1; i_num_entries = 7'(n); cycle(); i_start = 1'b0;
  endtask

  task automatic commit(input logic [127:0] obs);
    i_valid = 1'b1; i_obs = obs; cycle(); i_valid = 1'b0;
  endtask

  task automatic prog(input int a, input int ch, input logic [31:0] d, input bit m);
    i_prog_we = 1'b1; i_prog_addr = 6'(a); i_prog_ch = 2'(ch);
    i_prog_data = d; i_prog_mask = m;
    cycle(); i_prog_we = 1'b0;
  endtask

  task automatic prog_entry1(input int a, input logic [31:0] v);
    prog(a, 0, v, 1'b1);
    for (int c = 1; c < 4; c++) prog(a, c, 32'd0, 1'b0);
  endtask

  function automatic logic [127:0] ob0(input logic [31:0] v);
    return {96'b0, v};
  endfunction

  task automatic test_reset();
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (d_state[k] !== 2'd0 || d_tests[k] !== 16'd0 || d_passes[k] !== 16'd0 ||
          d_fail[k] !== 1'b0 || d_done[k] !== 1'b0 || d_idx[k] !== 6'd0 || d_ch[k] !== 2'd0) begin
        bad++;
        $display("FAIL reset_k%0d state=%0d tests=%0d passes=%0d fail=%0b done=%0b want all zero",
                 k, d_state[k], d_tests[k], d_passes[k], d_fail[k], d_done[k]);
      end
    end
  endtask

  task automatic test_basic_pass();
    prog_entry1(0, 32'd5);
    prog_entry1(1, 32'd4);
    start(2);
    total++; if (d_state[0] !== 2'd1) begin bad++; $display("FAIL basic_run state=%0d want=1", d_state[0]); end
    commit(ob0(32'd5));
    total++; if (d_tests[0] !== 16'd1) begin bad++; $display("FAIL basic_tests1 got=%0d want=1", d_tests[0]); end
    total++; if (d_state[0] !== 2'd1) begin bad++; $display("FAIL basic_mid_state got=%0d want=1", d_state[0]); end
    commit(ob0(32'd4));
    total++; if (d_tests[0] !== 16'd2 || d_passes[0] !== 16'd2) begin
      bad++; $display("FAIL basic_counts tests=%0d passes=%0d want 2/2", d_tests[0], d_passes[0]); end
    total++; if (d_fail[0] !== 1'b0) begin bad++; $display("FAIL basic_fail got=%0b want=0", d_fail[0]); end
    total++; if (d_state[0] !== 2'd2 || d_done[0] !== 1'b1) begin
      bad++; $display("FAIL basic_done state=%0d done=%0b want 2/1", d_state[0], d_done[0]); end
  endtask

  task automatic test_multi_channel();
    prog(0, 0, 32'h76767000, 1'b1); prog(0, 1, 32'd1, 1'b1);
    prog(0, 2, 32'd0, 1'b0);        prog(0, 3, 32'd0, 1'b0);
    prog_entry1(1, 32'h76767000);
    start(2);
    commit({64'b0, 32'd1, 32'h76767000});
    total++; if (d_tests[0] !== 16'd2 || d_passes[0] !== 16'd2) begin
      bad++; $display("FAIL multi_first tests=%0d passes=%0d want 2/2", d_tests[0], d_passes[0]); end
    commit({64'b0, 32'd1, 32'h76767004});
    total++; if (d_tests[0] !== 16'd3 || d_passes[0] !== 16'd2) begin
      bad++; $display("FAIL multi_second tests=%0d passes=%0d want 3/2", d_tests[0], d_passes[0]); end
    total++; if (d_fail[0] !== 1'b1 || d_idx[0] !== 6'd1 || d_ch[0] !== 2'd0) begin
      bad++; $display("FAIL multi_capture fail=%0b idx=%0d ch=%0d want 1/1/0", d_fail[0], d_idx[0], d_ch[0]); end
  endtask

  task automatic test_stop_on_fail();
    for (int i = 0; i < 4; i++) prog_entry1(i, 32'(10 + i));
    start(4);
    commit(ob0(32'd10));
    commit(ob0(32'd99));
    total++; if (d_state[1] !== 2'd2 || d_tests[1] !== 16'd2 || d_passes[1] !== 16'd1) begin
      bad++; $display("FAIL stop_enter state=%0d tests=%0d passes=%0d want 2/2/1", d_state[1], d_tests[1], d_passes[1]); end
    total++; if (d_fail[1] !== 1'b1 || d_idx[1] !== 6'd1) begin
      bad++; $display("FAIL stop_capture fail=%0b idx=%0d want 1/1", d_fail[1], d_idx[1]); end
    commit(ob0(32'd12));
    total++; if (d_state[1] !== 2'd2 || d_tests[1] !== 16'd2) begin
      bad++; $display("FAIL stop_ignore state=%0d tests=%0d want 2/2", d_state[1], d_tests[1]); end
    total++; if (d_state[0] !== 2'd1 || d_tests[0] !== 16'd3) begin
      bad++; $display("FAIL stop_main_runs state=%0d tests=%0d want 1/3", d_state[0], d_tests[0]); end
    commit(ob0(32'd13));
    total++; if (d_state[0] !== 2'd2 || d_passes[0] !== 16'd3) begin
      bad++; $display("FAIL stop_main_done state=%0d passes=%0d want 2/3", d_state[0], d_passes[0]); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 6; i++) prog_entry1(i, 32'(100 + i));
    start(6);
    for (int i = 0; i < 3; i++) commit(ob0(32'(100 + i)));
    total++; if (d_tests[0] !== 16'd3) begin bad++; $display("FAIL midrst_pre tests=%0d want=3", d_tests[0]); end
    do_reset();
    total++; if (d_state[0] !== 2'd0 || d_tests[0] !== 16'd0 || d_passes[0] !== 16'd0) begin
      bad++; $display("FAIL midrst_idle state=%0d tests=%0d passes=%0d want 0/0/0", d_state[0], d_tests[0], d_passes[0]); end
    start(6);
    for (int i = 0; i < 6; i++) commit(ob0(32'(100 + i)));
    total++; if (d_tests[0] !== 16'd6 || d_passes[0] !== 16'd6 || d_state[0] !== 2'd2) begin
      bad++; $display("FAIL midrst_rerun tests=%0d passes=%0d state=%0d want 6/6/2", d_tests[0], d_passes[0], d_state[0]); end
  endtask

  task automatic test_gap();
    start(6);
    commit(ob0(32'd100));
    for (int g = 0; g < 5; g++) begin
      if (g == 2) begin i_start = 1'b1; i_num_entries = 7'd2; end
      cycle();
      i_start = 1'b0;
      total++; if (d_tests[0] !== 16'd1 || d_state[0] !== 2'd1) begin
        bad++; $display("FAIL gap_hold g=%0d tests=%0d state=%0d want 1/1", g, d_tests[0], d_state[0]); end
    end
    for (int i = 1; i < 6; i++) commit(ob0(32'(100 + i)));
    total++; if (d_tests[0] !== 16'd6 || d_state[0] !== 2'd2) begin
      bad++; $display("FAIL gap_end tests=%0d state=%0d want 6/2", d_tests[0], d_state[0]); end
  endtask

  task automatic test_num_zero();
    start(0);
    total++; if (d_state[0] !== 2'd2 || d_done[0] !== 1'b1 || d_tests[0] !== 16'd0) begin
      bad++; $display("FAIL zero_entries state=%0d done=%0b tests=%0d want 2/1/0", d_state[0], d_done[0], d_tests[0]); end
  endtask

  task automatic test_prog_in_run();
    start(6);
    commit(ob0(32'd100));
    prog(0, 0, 32'd555, 1'b1);
    prog(1, 0, 32'd777, 1'b0);
    for (int i = 1; i < 6; i++) commit(ob0(32'(100 + i)));
    start(6);
    commit(ob0(32'd100));
    total++; if (d_passes[0] !== 16'd1 || d_fail[0] !== 1'b0) begin
      bad++; $display("FAIL prog_ignored passes=%0d fail=%0b want 1/0", d_passes[0], d_fail[0]); end
    commit(ob0(32'd101));
    total++; if (d_tests[0] !== 16'd2 || d_passes[0] !== 16'd2) begin
      bad++; $display("FAIL prog_mask_kept tests=%0d passes=%0d want 2/2", d_tests[0], d_passes[0]); end
    for (int i = 2; i < 6; i++) commit(ob0(32'(100 + i)));
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) prog_entry1(i, 32'(3 * i));
    start(20);
    for (int i = 0; i < 20; i++) commit(ob0(32'(3 * i)));
    cycle();
    total++; if (d_tests[2] !== 16'd15 || d_passes[2] !== 16'd15 || d_state[2] !== 2'd2) begin
      bad++; $display("FAIL sat_hold tests=%0d passes=%0d state=%0d want 15/15/2", d_tests[2], d_passes[2], d_state[2]); end
    total++; if (d_tests[0] !== 16'd20) begin bad++; $display("FAIL sat_wide tests=%0d want=20", d_tests[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int a = 0; a < 64; a++)
      for (int c = 0; c < 4; c++) prog(a, c, 32'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    for (int r = 0; r < 8; r++) begin
      int n, cyc;
      n = (r == 0) ? 0 : (r == 1) ? 100 : (r == 2) ? 64 : int'($urandom_range(1, 24));
      start(n);
      cyc = 0;
      while (m_st[0] == 1 && cyc < 400) begin
        i_valid = ($urandom_range(0, 9) < 7);
        for (int c = 0; c < 4; c++)
          i_obs[c*32 +: 32] = ($urandom_range(0, 3) != 0) ? g_val[0][m_ptr[0] % 64][c] : $urandom;
        i_prog_we = ($urandom_range(0, 9) == 0);
        i_prog_addr = 6'($urandom); i_prog_ch = 2'($urandom);
        i_prog_data = 32'($urandom_range(0, 3)); i_prog_mask = 1'($urandom);
        i_start = ($urandom_range(0, 19) == 0); i_num_entries = 7'($urandom_range(0, 30));
        cycle();
        cyc++;
        for (int k = 0; k < 3; k++) begin
          total++;
          if (d_state[k] !== 2'(m_st[k]) || d_tests[k] !== 16'(m_tests[k]) ||
              d_passes[k] !== 16'(m_passes[k]) || d_fail[k] !== m_fail[k] ||
              d_idx[k] !== 6'(m_idx[k]) || d_ch[k] !== 2'(m_ch[k]) || d_done[k] !== (m_st[k] == 2)) begin
            bad++;
            $display("FAIL rand_k%0d r%0d c%0d state %0d/%0d tests %0d/%0d passes %0d/%0d fail %0b/%0b idx %0d/%0d ch %0d/%0d",
                     k, r, cyc, d_state[k], m_st[k], d_tests[k], m_tests[k], d_passes[k], m_passes[k],
                     d_fail[k], m_fail[k], d_idx[k], m_idx[k], d_ch[k], m_ch[k]);
          end
        end
      end
      i_valid = 1'b0; i_prog_we = 1'b0; i_start = 1'b0;
      total++;
      if (m_st[0] == 1) begin bad++; $display("FAIL rand_timeout r%0d still running after %0d cycles", r, cyc); end
    end
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_num_entries = '0; i_valid = 1'b0; i_obs = '0;
    i_prog_we = 1'b0; i_prog_addr = '0; i_prog_ch = '0; i_prog_data = '0; i_prog_mask = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_ptr[k] = 0; m_num[k] = 0; m_tests[k] = 0; m_passes[k] = 0;
      m_fail[k] = 0; m_idx[k] = 0; m_ch[k] = 0;
    end
    test_reset();
    test_basic_pass();
    test_multi_channel();
    test_stop_on_fail();
    test_reset_mid_run();
    test_gap();
    test_num_zero();
    test_prog_in_run();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
